// File: rtl/iserdes_period_meter.sv
// Converts ISERDES edge reports into 1/8-clock timestamps and measures the duration of EDGES
// back-to-back half-periods, presenting each result on a valid/ready output register.
module iserdes_period_meter #(
    parameter int unsigned CNT_WIDTH      = 20,
    parameter int unsigned EDGES          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 changed_flag_i,
    input  logic [2:0]           changed_bit_i,
    output logic [CNT_WIDTH+2:0] period_out_o,
    output logic                 period_valid_o,
    input  logic                 period_ready_i,
    output logic                 overrun_o,
    output logic                 no_signal_o
);

    localparam int unsigned TsW  = CNT_WIDTH + 3;
    localparam int unsigned EcW  = $clog2(EDGES + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    if (EDGES < 2 || EDGES > 256) begin : gen_bad_edges
        $error("EDGES must be in 2..256");
    end
    if (64'(EDGES) * 64'(TIMEOUT_CYCLES) >= (64'd1 << CNT_WIDTH)) begin : gen_bad_width
        $error("EDGES*TIMEOUT_CYCLES must be below 2**CNT_WIDTH");
    end

    typedef enum logic {StWaitFirst, StMeasure} state_e;

    state_e             state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [TsW-1:0]     start_ts_q, start_ts_d;
    logic [TsW-1:0]     out_q, out_d;
    logic [TsW-1:0]     ts, result;
    logic [EcW-1:0]     edge_cnt_q, edge_cnt_d, edge_inc;
    logic [TmoW-1:0]    tmo_q, tmo_d;
    logic               nosig_q, nosig_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
    logic               res_vld, handshake, drop;

    // Modular subtraction makes counter wrap inside a window transparent.
    assign ts        = {cnt_q, changed_bit_i};
    assign result    = ts - start_ts_q;
    assign edge_inc  = edge_cnt_q + EcW'(1);
    assign handshake = valid_q & period_ready_i;
    assign drop      = res_vld & valid_q & ~period_ready_i;

    always_comb begin
        state_d    = state_q;
        start_ts_d = start_ts_q;
        edge_cnt_d = edge_cnt_q;
        nosig_d    = nosig_q;
        res_vld    = 1'b0;
        tmo_d      = tmo_q;

        if (changed_flag_i) begin
            tmo_d = '0;
        end else if (tmo_q != TmoW'(TIMEOUT_CYCLES)) begin
            tmo_d = tmo_q + TmoW'(1);
        end

        unique case (state_q)
            StWaitFirst: begin
                if (changed_flag_i) begin
                    start_ts_d = ts;
                    edge_cnt_d = '0;
                    nosig_d    = 1'b0;
                    state_d    = StMeasure;
                end
            end
            StMeasure: begin
                if (changed_flag_i) begin
                    // The closing edge also opens the next window.
                    if (edge_inc == EcW'(EDGES)) begin
                        res_vld    = 1'b1;
                        start_ts_d = ts;
                        edge_cnt_d = '0;
                    end else begin
                        edge_cnt_d = edge_inc;
                    end
                end else if (tmo_d == TmoW'(TIMEOUT_CYCLES)) begin
                    nosig_d    = 1'b1;
                    edge_cnt_d = '0;
                    state_d    = StWaitFirst;
                end
            end
            default: state_d = StWaitFirst;
        endcase
    end

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        if (res_vld && (!valid_q || period_ready_i)) begin
            out_d   = result;
            valid_d = 1'b1;
        end else if (handshake) begin
            valid_d = 1'b0;
        end
        overrun_d = drop ? 1'b1 : (handshake ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            state_q    <= StWaitFirst;
            start_ts_q <= '0;
            edge_cnt_q <= '0;
            tmo_q      <= '0;
            nosig_q    <= 1'b1;
            out_q      <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_q + CNT_WIDTH'(1);
            state_q    <= state_d;
            start_ts_q <= start_ts_d;
            edge_cnt_q <= edge_cnt_d;
            tmo_q      <= tmo_d;
            nosig_q    <= nosig_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign period_out_o   = out_q;
    assign period_valid_o = valid_q;
    assign overrun_o      = overrun_q;
    assign no_signal_o    = nosig_q;

endmodule
